dt_rx_ctrl: RTL and testbench
=============================

Name: dt_rx_ctrl

Overview:
Receive-side packet assembler, the counterpart of the transmit byte serializer. Takes framed bytes from the UART receiver and rebuilds the {sel, data} packet that the serializer consumes. Writes each complete packet into the downstream packet FIFO as one 51-bit word. Frame format: one header byte, then sel+1 payload bytes sent LSB byte first.

Parameters:
DATA_PACKET_WIDTH, 51, packet width: {sel[2:0], data[47:0]}
UART_DATA_WIDTH, 8, byte width
SEL_WIDTH, 3, byte-count field width (sel = payload bytes - 1)
DATA_WIDTH, 48, payload field width
SYNC_NIBBLE, 4'hA, required value of header[7:4]
TIMEOUT_CYCLES, 50000, max idle clocks between payload bytes; must be >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
data_byte  input  8  received byte from UART RX, valid when rx_valid=1
rx_valid  input  1  one-cycle strobe per received byte
f_full  input  1  packet FIFO full
data_packet  output  51  assembled packet {sel, data}, valid when wr_en=1
wr_en  output  1  FIFO write strobe, exactly one cycle per packet
frame_err  output  1  one-cycle pulse on a bad header or an inter-byte timeout
overflow  output  1  one-cycle pulse when a byte is dropped while a write is pending
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE. wr_en, frame_err, overflow=0. data_packet=0. Internal sel, data, byte_cnt and timer all 0. Asserting rst_n low mid-frame discards the partial packet immediately.
- States:
  - IDLE: waiting for a header.
  - COLLECT: receiving payload bytes.
  - WRITE: holding a complete packet for the FIFO.
- IDLE, rx_valid=1:
  - Valid header when data_byte[7:4]==SYNC_NIBBLE, data_byte[3]==0 and data_byte[2:0]<=5.
  - Valid header: latch sel=data_byte[2:0], clear data, byte_cnt=0, timer=0, go to COLLECT.
  - Any other byte: frame_err=1 for the next cycle, stay in IDLE.
- COLLECT, rx_valid=1:
  - Store the byte at data[byte_cnt*8 +: 8] and clear the timer.
  - If byte_cnt==sel, go to WRITE; otherwise byte_cnt+1.
- COLLECT, rx_valid=0:
  - Timer increments.
  - When timer reaches TIMEOUT_CYCLES-1: frame_err pulse, packet discarded, go to IDLE, no write.
- Unused upper payload bytes are 0 (e.g. sel=2 gives data[47:24]=0).
- WRITE, f_full=0: register data_packet={sel,data} and wr_en=1, return to IDLE.
  - wr_en is high the second clock after the last payload byte's rx_valid cycle.
- WRITE, f_full=1: hold in WRITE with wr_en=0 and the packet retained. There is no timeout in WRITE.
- rx_valid while in WRITE: byte dropped, overflow pulse next cycle, packet unaffected.
- wr_en is never high while f_full is high in the same cycle it was decided; the write decision samples f_full.
- data_packet holds its value after wr_en until the next write.
- A header arriving in IDLE in the same cycle wr_en is high is accepted normally, so back-to-back frames need no gap.
- frame_err and overflow are never both asserted from a single byte.

Test Plan:
- Header 0xA2, then 0x11, 0x22, 0x33 at arbitrary spacing below the timeout -> one wr_en pulse, data_packet=51'h2_0000_0033_2211, frame_err=0.
- Header 0xA5, then 0x01..0x06 back-to-back, then immediately header 0xA0 and 0x7F -> two wr_en pulses:
  - first packet 51'h5_0605_0403_0201,
  - second packet 51'h0_0000_0000_007F.
- Bytes 0x52, then 0xA6, then 0xA8 in IDLE -> three frame_err pulses, no wr_en, busy stays 0.
- Header 0xA1, one byte 0x55, then no rx_valid for TIMEOUT_CYCLES -> frame_err pulse on the timeout cycle, no wr_en. A following frame 0xA0, 0x99 -> packet 51'h0_0000_0000_0099.
- f_full=1 when the last byte of 0xA0, 0x42 arrives, held for 20 cycles; an extra byte arrives during the stall:
  - overflow pulses once,
  - wr_en asserts one cycle after f_full falls,
  - data_packet=51'h0_0000_0000_0042.
- rst_n pulsed low after 2 of 4 payload bytes -> all outputs 0 during reset, no wr_en. A fresh frame after release assembles correctly with no stale data.

Source files
------------

// File: rtl/dt_rx_ctrl.sv
// Receive-side packet assembler: turns a header byte plus sel+1 payload bytes
// (LSB byte first) into one {sel, data} word written to the packet FIFO.
module dt_rx_ctrl #(
    parameter int unsigned DATA_PACKET_WIDTH = 51,
    parameter int unsigned UART_DATA_WIDTH   = 8,
    parameter int unsigned SEL_WIDTH         = 3,
    parameter int unsigned DATA_WIDTH        = 48,
    parameter logic [3:0]  SYNC_NIBBLE       = 4'hA,
    parameter int unsigned TIMEOUT_CYCLES    = 50000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [UART_DATA_WIDTH-1:0]   data_byte,
    input  logic                         rx_valid,
    input  logic                         f_full,
    output logic [DATA_PACKET_WIDTH-1:0] data_packet,
    output logic                         wr_en,
    output logic                         frame_err,
    output logic                         overflow,
    output logic                         busy
);

    localparam int unsigned NUM_BYTES   = DATA_WIDTH / UART_DATA_WIDTH;
    localparam int unsigned TIMER_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [SEL_WIDTH-1:0]   SEL_MAX      = SEL_WIDTH'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StWrite
    } state_t;

    state_t                         state_q, state_d;
    logic [SEL_WIDTH-1:0]           sel_q, sel_d;
    logic [DATA_WIDTH-1:0]          data_q, data_d;
    logic [SEL_WIDTH-1:0]           cnt_q, cnt_d;
    logic [TIMER_WIDTH-1:0]         timer_q, timer_d;
    logic [DATA_PACKET_WIDTH-1:0]   packet_q, packet_d;
    logic                           wr_en_q, wr_en_d;
    logic                           frame_err_q, frame_err_d;
    logic                           overflow_q, overflow_d;
    logic                           hdr_ok;

    assign hdr_ok = (data_byte[7:4] == SYNC_NIBBLE) && !data_byte[3] &&
                    (data_byte[SEL_WIDTH-1:0] <= SEL_MAX);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        packet_d    = packet_q;
        wr_en_d     = 1'b0;
        frame_err_d = 1'b0;
        overflow_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    if (hdr_ok) begin
                        sel_d   = data_byte[SEL_WIDTH-1:0];
                        data_d  = '0;
                        cnt_d   = '0;
                        timer_d = '0;
                        state_d = StCollect;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            StCollect: begin
                if (rx_valid) begin
                    for (int i = 0; i < NUM_BYTES; i++) begin
                        if (cnt_q == SEL_WIDTH'(i)) begin
                            data_d[i*UART_DATA_WIDTH +: UART_DATA_WIDTH] = data_byte;
                        end
                    end
                    timer_d = '0;
                    if (cnt_q == sel_q) begin
                        state_d = StWrite;
                    end else begin
                        cnt_d = cnt_q + SEL_WIDTH'(1);
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    // Inter-byte gap too long: drop the partial frame.
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    timer_d = timer_q + TIMER_WIDTH'(1);
                end
            end
            StWrite: begin
                overflow_d = rx_valid;
                if (!f_full) begin
                    packet_d = {sel_q, data_q};
                    wr_en_d  = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            packet_q    <= '0;
            wr_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            packet_q    <= packet_d;
            wr_en_q     <= wr_en_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign data_packet = packet_q;
    assign wr_en       = wr_en_q;
    assign frame_err   = frame_err_q;
    assign overflow    = overflow_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_dt_rx_ctrl.sv
// Scoreboard bench for dt_rx_ctrl: the driver pushes expected packets and pulse
// cycles as it sends frames; a negedge monitor pops and compares them.
module tb_dt_rx_ctrl;

    localparam int unsigned T = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_byte;
    logic        rx_valid;
    logic        f_full;
    logic [50:0] data_packet;
    logic        wr_en;
    logic        frame_err;
    logic        overflow;
    logic        busy;

    dt_rx_ctrl #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_byte  (data_byte),
        .rx_valid   (rx_valid),
        .f_full     (f_full),
        .data_packet(data_packet),
        .wr_en      (wr_en),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [50:0] pkt;
    } exp_pkt_t;

    exp_pkt_t    pkt_q[$];
    int          err_q[$];
    int          ovf_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [50:0] last_pkt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Each edge's outputs are compared at the following negedge.
    always @(negedge clk) begin
        exp_pkt_t e;
        if (!rst_n) begin
            last_pkt = '0;
        end else begin
            if (wr_en) begin
                checks++;
                if (pkt_q.size() == 0) begin
                    failures++;
                    $display("FAIL wr_en_unexpected: got pkt %h at cycle %0d, required no write",
                             data_packet, cyc);
                end else begin
                    e = pkt_q.pop_front();
                    if (e.cyc != cyc || data_packet !== e.pkt) begin
                        failures++;
                        $display("FAIL packet: got %h at cycle %0d, required %h at cycle %0d",
                                 data_packet, cyc, e.pkt, e.cyc);
                    end
                    last_pkt = e.pkt;
                end
            end else begin
                if (pkt_q.size() > 0 && pkt_q[0].cyc <= cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_en_missing: got none at cycle %0d, required pkt %h",
                             cyc, pkt_q[0].pkt);
                    void'(pkt_q.pop_front());
                end
                checks++;
                if (data_packet !== last_pkt) begin
                    failures++;
                    $display("FAIL packet_hold: got %h, required %h at cycle %0d",
                             data_packet, last_pkt, cyc);
                end
            end
            if (frame_err) begin
                checks++;
                if (err_q.size() == 0 || err_q[0] != cyc) begin
                    failures++;
                    $display("FAIL frame_err: got pulse at cycle %0d, required %0d",
                             cyc, (err_q.size() > 0) ? err_q[0] : -1);
                end
                if (err_q.size() > 0 && err_q[0] <= cyc) void'(err_q.pop_front());
            end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
                checks++;
                failures++;
                $display("FAIL frame_err_missing: got 0 at cycle %0d, required 1", cyc);
                void'(err_q.pop_front());
            end
            if (overflow) begin
                checks++;
                if (ovf_q.size() == 0 || ovf_q[0] != cyc) begin
                    failures++;
                    $display("FAIL overflow: got pulse at cycle %0d, required %0d",
                             cyc, (ovf_q.size() > 0) ? ovf_q[0] : -1);
                end
                if (ovf_q.size() > 0 && ovf_q[0] <= cyc) void'(ovf_q.pop_front());
            end else if (ovf_q.size() > 0 && ovf_q[0] <= cyc) begin
                checks++;
                failures++;
                $display("FAIL overflow_missing: got 0 at cycle %0d, required 1", cyc);
                void'(ovf_q.pop_front());
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Drive one clock's worth of inputs; returns #1 after the sampling edge.
    task automatic step(input logic v, input logic [7:0] b, input logic f);
        rx_valid  = v;
        data_byte = b;
        f_full    = f;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'($urandom), 1'($urandom));
    endtask

    task automatic bad_header(input logic [7:0] b);
        step(1'b1, b, 1'($urandom));
        err_q.push_back(cyc);
        chk("busy_after_bad_header", 64'(busy), 64'd0);
    endtask

    // Send a frame; to_idx >= 0 withholds that payload byte long enough to time out.
    task automatic send_frame(input logic [2:0] sel, input logic [47:0] pl, input int max_gap,
                              input int stall, input int extra_at, input int to_idx);
        logic [47:0] exp_data;
        exp_pkt_t    e;
        exp_data = '0;
        step(1'b1, {4'hA, 1'b0, sel}, 1'($urandom));
        chk("busy_after_header", 64'(busy), 64'd1);
        for (int i = 0; i <= int'(sel); i++) begin
            if (i == to_idx) begin
                step(1'b0, 8'h00, 1'($urandom));
                idle(T - 1);
                err_q.push_back(cyc);
                return;
            end
            idle($urandom_range(0, max_gap));
            step(1'b1, pl[i*8 +: 8], (i == int'(sel) && stall > 0) ? 1'b1 : 1'($urandom));
            exp_data[i*8 +: 8] = pl[i*8 +: 8];
        end
        for (int s = 0; s < stall; s++) begin
            if (s == extra_at) begin
                step(1'b1, 8'($urandom), 1'b1);
                ovf_q.push_back(cyc);
            end else begin
                step(1'b0, 8'($urandom), 1'b1);
            end
        end
        step(1'b0, 8'($urandom), 1'b0);
        e.cyc = cyc;
        e.pkt = {sel, exp_data};
        pkt_q.push_back(e);
    endtask

    initial begin
        logic [63:0] r;
        logic [7:0]  b;
        int          sel;
        int          stall;
        int          extra;
        int          to_idx;

        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        data_byte = '0;
        f_full    = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_wr_en", 64'(wr_en), 64'd0);
        chk("reset_frame_err", 64'(frame_err), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_data_packet", 64'(data_packet), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        send_frame(3'd2, 48'h0000_0033_2211, 6, 0, -1, -1);
        send_frame(3'd5, 48'h0605_0403_0201, 0, 0, -1, -1);
        send_frame(3'd0, 48'h0000_0000_007F, 0, 0, -1, -1);
        chk("busy_after_write", 64'(busy), 64'd0);
        bad_header(8'h52);
        bad_header(8'hA6);
        bad_header(8'hA8);
        send_frame(3'd1, 48'h0000_0000_0055, 0, 0, -1, 1);
        send_frame(3'd0, 48'h0000_0000_0099, 2, 0, -1, -1);
        send_frame(3'd0, 48'h0000_0000_0042, 2, 20, 7, -1);
        idle(3);

        // Reset mid-frame after two of four payload bytes.
        step(1'b1, 8'hA3, 1'b0);
        step(1'b1, 8'hDE, 1'b0);
        step(1'b1, 8'hAD, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midreset_wr_en", 64'(wr_en), 64'd0);
        chk("midreset_frame_err", 64'(frame_err), 64'd0);
        chk("midreset_overflow", 64'(overflow), 64'd0);
        chk("midreset_data_packet", 64'(data_packet), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        step(1'b1, 8'hBE, 1'b0);
        step(1'b1, 8'hEF, 1'b0);
        rst_n = 1'b1;
        idle(1);
        send_frame(3'd3, 48'h0000_4433_2211, 3, 0, -1, -1);

        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 99) < 15) begin
                do b = 8'($urandom); while (b[7:4] == 4'hA && !b[3] && b[2:0] <= 3'd5);
                bad_header(b);
            end else begin
                r      = {$urandom, $urandom};
                sel    = $urandom_range(0, 5);
                stall  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
                extra  = (stall > 0 && $urandom_range(0, 9) < 3) ? $urandom_range(0, stall - 1) : -1;
                to_idx = ($urandom_range(0, 9) == 0) ? $urandom_range(0, sel) : -1;
                send_frame(3'(sel), r[47:0], 3, stall, extra, to_idx);
            end
            idle($urandom_range(0, 2));
        end
        idle(4);

        chk("pkt_queue_drained", 64'(pkt_q.size()), 64'd0);
        chk("err_queue_drained", 64'(err_q.size()), 64'd0);
        chk("ovf_queue_drained", 64'(ovf_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
